spi_master_core: RTL

Clock-oversampled SPI master that drives select/mclk/mosi and captures miso for one frame of NBYTES bytes. It sits directly upstream of the team's busy SPI slave: its select/mclk/mosi pins feed the slave's select/mclk/mosi inputs, and the slave's miso feeds this block's miso. It is also used standalone to talk to external SPI devices. Host side is a start/busy/done handshake carrying parallel words.

---
 rtl/spi_master_core_if.sv | 37 +++
 rtl/spi_master_core.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_core_if.sv
// spi_master_core_if: host handshake plus SPI pin bundle for spi_master_core.
// Latency: none (wires only).
// Backpressure: start is dropped by the core while busy=1; nothing in here holds it.
interface spi_master_core_if #(
    parameter int NBYTES = 1,
    parameter int DIVW   = 8
);
    // Host-side frame configuration; only looked at when a frame is accepted.
    logic                  cpol;
    logic                  cpha;
    logic [DIVW-1:0]       div;
    logic                  start;
    logic [8*NBYTES-1:0]   din;

    // Host-side results.
    logic [8*NBYTES-1:0]   dout;
    logic                  busy;
    logic                  done;

    // SPI pins.
    logic                  select;
    logic                  mclk;
    logic                  mosi;
    logic                  miso;

    // The SPI master core itself.
    modport master (
        input  cpol, cpha, div, start, din, miso,
        output dout, busy, done, select, mclk, mosi
    );

    // Whatever drives the core: host logic plus the far-end SPI device.
    modport slave (
        output cpol, cpha, div, start, din, miso,
        input  dout, busy, done, select, mclk, mosi
    );
endinterface

// File: rtl/spi_master_core.sv
// spi_master_core: clk-oversampled SPI master, one NBYTES frame per start, any cpol/cpha.
// Latency: select/busy rise 1 clk after accept; done at T+1+(16N+1)*H; busy falls at T+1+(16N+2)*H.
// Backpressure: start is honoured only while busy=0; requests during a frame are dropped, not queued.
module spi_master_core #(
    parameter int NBYTES = 1,
    parameter int DIVW   = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    spi_master_core_if.master spi
);
    localparam int W     = 8 * NBYTES;
    localparam int NEDGE = 16 * NBYTES;
    localparam int CW    = $clog2(NEDGE) + 1;

    localparam logic [CW-1:0]   EDGE_LAST = CW'(NEDGE);
    localparam logic [CW-1:0]   EDGE_ONE  = CW'(1);
    localparam logic [DIVW-1:0] HC_ONE    = DIVW'(1);

    // LEAD and SHIFT share the edge machinery; LEAD is just "no edge issued yet".
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t          state_q;
    logic            cpha_q;
    logic [DIVW-1:0] div_q;
    logic [DIVW-1:0] hc_q;
    logic [CW-1:0]   ecnt_q;
    logic [W-1:0]    tx_q;
    logic [W-1:0]    rx_q;
    logic [W-1:0]    dout_q;
    logic            busy_q;
    logic            done_q;
    logic            select_q;
    logic            mclk_q;
    logic            mosi_q;
    logic            miso_x_q;

    // Properties of the edge that would be issued this cycle if the half-period expires.
    logic [CW-1:0]   ecnt_d;
    logic            hc_zero;
    logic            edge_lead;
    logic            edge_sample;
    logic            edge_last;
    logic            edge_shift_lead;
    logic            edge_shift_trail;

    // Decode the upcoming edge: odd edges are leading, the sample edge depends on cpha.
    always_comb begin
        ecnt_d           = ecnt_q + EDGE_ONE;
        hc_zero          = (hc_q == '0);
        edge_lead        = ecnt_d[0];
        edge_sample      = edge_lead ^ cpha_q;
        edge_last        = (ecnt_d == EDGE_LAST);
        // cpha=1 drives the current bit on the leading edge, first bit at edge 1.
        edge_shift_lead  = cpha_q & edge_lead;
        // cpha=0 already shows the MSB from accept; the final trailing edge has no next bit.
        edge_shift_trail = ~cpha_q & ~edge_lead & ~edge_last;
    end

    // Register miso once so the sample edge always uses a clean, clk-aligned value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            miso_x_q <= 1'b0;
        end else begin
            miso_x_q <= spi.miso;
        end
    end

    // Frame sequencer: accept, lead-in, 16N mclk edges, trail-out, deselect gap.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            hc_q     <= '0;
            ecnt_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            select_q <= 1'b0;
            mclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Idle clock level tracks cpol so the pin is already right at accept.
                    mclk_q <= spi.cpol;
                    if (spi.start) begin
                        cpha_q   <= spi.cpha;
                        div_q    <= spi.div;
                        hc_q     <= spi.div;
                        ecnt_q   <= '0;
                        tx_q     <= spi.din;
                        rx_q     <= '0;
                        select_q <= 1'b1;
                        busy_q   <= 1'b1;
                        if (!spi.cpha) begin
                            mosi_q <= spi.din[W-1];
                        end
                        state_q  <= ST_LEAD;
                    end
                end

                ST_LEAD, ST_SHIFT: begin
                    if (hc_zero) begin
                        hc_q   <= div_q;
                        mclk_q <= ~mclk_q;
                        ecnt_q <= ecnt_d;
                        if (edge_sample) begin
                            rx_q <= {rx_q[W-2:0], miso_x_q};
                        end
                        if (edge_shift_lead) begin
                            mosi_q <= tx_q[W-1];
                            tx_q   <= {tx_q[W-2:0], 1'b0};
                        end else if (edge_shift_trail) begin
                            mosi_q <= tx_q[W-2];
                            tx_q   <= {tx_q[W-2:0], 1'b0};
                        end
                        // An even edge count always leaves mclk back at cpol.
                        state_q <= edge_last ? ST_TRAIL : ST_SHIFT;
                    end else begin
                        hc_q <= hc_q - HC_ONE;
                    end
                end

                ST_TRAIL: begin
                    if (hc_zero) begin
                        hc_q     <= div_q;
                        select_q <= 1'b0;
                        dout_q   <= rx_q;
                        done_q   <= 1'b1;
                        state_q  <= ST_GAP;
                    end else begin
                        hc_q <= hc_q - HC_ONE;
                    end
                end

                ST_GAP: begin
                    // Minimum deselect time before the next frame may be accepted.
                    if (hc_zero) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hc_q <= hc_q - HC_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi.dout   = dout_q;
    assign spi.busy   = busy_q;
    assign spi.done   = done_q;
    assign spi.select = select_q;
    assign spi.mclk   = mclk_q;
    assign spi.mosi   = mosi_q;
endmodule
